// File: rtl/sigmoid_act_stream.sv
// Streaming sigmoid activation: PLAN piecewise-linear approximation in a 2-stage elastic pipeline.
// Optional derivative output y*(1-y) is enabled with `define SIGMOID_ACT_DERIV_OUT_EN.
module sigmoid_act_stream #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] z_i,
    output logic                  valid_o,
    input  logic                  ready_i,
`ifdef SIGMOID_ACT_DERIV_OUT_EN
    output logic [DATA_WIDTH-1:0] y_o,
    output logic [DATA_WIDTH-1:0] deriv_o
`else
    output logic [DATA_WIDTH-1:0] y_o
`endif
);

    localparam int AW = DATA_WIDTH + 1;

    typedef logic        [AW-1:0] mag_t;
    typedef logic signed [AW:0]   acc_t;

    localparam mag_t ONE      = mag_t'(1)  << FRAC_BITS;
    localparam mag_t TH_5P0   = mag_t'(5)  << FRAC_BITS;
    localparam mag_t TH_2P375 = mag_t'(19) << (FRAC_BITS - 3);
    localparam mag_t OFS_SEG0 = mag_t'(1)  << (FRAC_BITS - 1);
    localparam mag_t OFS_SEG1 = mag_t'(5)  << (FRAC_BITS - 3);
    localparam mag_t OFS_SEG2 = mag_t'(27) << (FRAC_BITS - 5);

    // One extra bit so the most-negative input has a representable magnitude.
    function automatic mag_t abs_ext(input logic signed [DATA_WIDTH-1:0] z);
        logic signed [AW-1:0] ze;
        ze = {z[DATA_WIDTH-1], z};
        return z[DATA_WIDTH-1] ? mag_t'(-ze) : mag_t'(ze);
    endfunction

    function automatic logic [1:0] seg_of(input mag_t a);
        if (a >= TH_5P0)        return 2'd3;
        else if (a >= TH_2P375) return 2'd2;
        else if (a >= ONE)      return 2'd1;
        else                    return 2'd0;
    endfunction

    function automatic mag_t plan_mag(input mag_t a, input logic [1:0] seg);
        case (seg)
            2'd0:    return (a >> 2) + OFS_SEG0;
            2'd1:    return (a >> 3) + OFS_SEG1;
            2'd2:    return (a >> 5) + OFS_SEG2;
            default: return ONE;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] sat_unit(input acc_t v);
        if (v < 0)                return '0;
        else if (v > acc_t'(ONE)) return DATA_WIDTH'(ONE);
        else                      return v[DATA_WIDTH-1:0];
    endfunction

`ifdef SIGMOID_ACT_DERIV_OUT_EN
    function automatic logic [DATA_WIDTH-1:0] deriv_of(input logic [DATA_WIDTH-1:0] y);
        logic [2*DATA_WIDTH-1:0] prod;
        prod = (2*DATA_WIDTH)'(y) * (2*DATA_WIDTH)'(DATA_WIDTH'(ONE) - y);
        return DATA_WIDTH'(prod >> FRAC_BITS);
    endfunction
`endif

    logic                  en1, en2, take_in, adv;
    logic signed [DATA_WIDTH-1:0] z_s;
    mag_t                  mag_in;
    acc_t                  p_s, y_raw;
    logic [DATA_WIDTH-1:0] y_new;

    logic                  vld_p1_q, vld_p1_d;
    logic                  sgn_p1_q, sgn_p1_d;
    mag_t                  mag_p1_q, mag_p1_d;
    logic [1:0]            seg_p1_q, seg_p1_d;
    logic                  vld_p2_q, vld_p2_d;
    logic [DATA_WIDTH-1:0] y_p2_q, y_p2_d;
`ifdef SIGMOID_ACT_DERIV_OUT_EN
    logic [DATA_WIDTH-1:0] deriv_p2_q, deriv_p2_d;
`endif

    always_comb begin
        en2     = ~vld_p2_q | ready_i;
        en1     = ~vld_p1_q | en2;
        take_in = valid_i & en1;
        adv     = vld_p1_q & en2;
    end

    assign ready_o = en1;
    assign z_s     = z_i;
    assign mag_in  = abs_ext(z_s);

    // Stage 1: sign, magnitude and segment select.
    always_comb begin
        vld_p1_d = en1 ? valid_i : vld_p1_q;
        sgn_p1_d = sgn_p1_q;
        mag_p1_d = mag_p1_q;
        seg_p1_d = seg_p1_q;
        if (take_in) begin
            sgn_p1_d = z_s[DATA_WIDTH-1];
            mag_p1_d = mag_in;
            seg_p1_d = seg_of(mag_in);
        end
    end

    // Stage 2: shift-add line, sign fold, clamp to [0, 1.0].
    always_comb begin
        p_s   = acc_t'(plan_mag(mag_p1_q, seg_p1_q));
        y_raw = sgn_p1_q ? (acc_t'(ONE) - p_s) : p_s;
        y_new = sat_unit(y_raw);
    end

    always_comb begin
        vld_p2_d = en2 ? vld_p1_q : vld_p2_q;
        y_p2_d   = adv ? y_new : y_p2_q;
`ifdef SIGMOID_ACT_DERIV_OUT_EN
        deriv_p2_d = adv ? deriv_of(y_new) : deriv_p2_q;
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_p1_q <= 1'b0;
            sgn_p1_q <= 1'b0;
            mag_p1_q <= '0;
            seg_p1_q <= '0;
            vld_p2_q <= 1'b0;
            y_p2_q   <= '0;
`ifdef SIGMOID_ACT_DERIV_OUT_EN
            deriv_p2_q <= '0;
`endif
        end else begin
            vld_p1_q <= vld_p1_d;
            sgn_p1_q <= sgn_p1_d;
            mag_p1_q <= mag_p1_d;
            seg_p1_q <= seg_p1_d;
            vld_p2_q <= vld_p2_d;
            y_p2_q   <= y_p2_d;
`ifdef SIGMOID_ACT_DERIV_OUT_EN
            deriv_p2_q <= deriv_p2_d;
`endif
        end
    end

    assign valid_o = vld_p2_q;
    assign y_o     = y_p2_q;
`ifdef SIGMOID_ACT_DERIV_OUT_EN
    assign deriv_o = deriv_p2_q;
`endif

endmodule

// File: tb/tb_sigmoid_act_stream.sv
// Scoreboard bench for sigmoid_act_stream (Q7.8 defaults); checks deriv_o when SIGMOID_ACT_DERIV_OUT_EN is defined.
module tb_sigmoid_act_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i, ready_i;
    logic        ready_o, valid_o;
    logic [15:0] z_i, y_o;
`ifdef SIGMOID_ACT_DERIV_OUT_EN
    logic [15:0] deriv_o;
`endif

    sigmoid_act_stream dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .z_i     (z_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
`ifdef SIGMOID_ACT_DERIV_OUT_EN
        .deriv_o (deriv_o),
`endif
        .y_o     (y_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] y;
        logic [15:0] d;
        int          cyc;
        bit          lat;
    } exp_t;
    exp_t sb_q[$];

    logic [15:0] exp_y_drv, exp_d_drv;
    bit          lat_drv   = 0;
    bit          in_stream = 0;
    int          strm_n = 0, strm_first = 0, strm_last = 0;
    int          n_pop = 0;
    bit          saw_stall = 0;
    bit          prev_stall = 0;
    logic [15:0] prev_y;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_y(input logic [15:0] z);
        int zi, a, p, y;
        zi = int'($signed(z));
        a  = (zi < 0) ? -zi : zi;
        if (a >= 1280)     p = 256;
        else if (a >= 608) p = 216 + a / 32;
        else if (a >= 256) p = 160 + a / 8;
        else               p = 128 + a / 4;
        y = (zi < 0) ? 256 - p : p;
        if (y < 0)   y = 0;
        if (y > 256) y = 256;
        return 16'(y);
    endfunction

    function automatic logic [15:0] ref_d(input logic [15:0] y);
        return 16'((int'(y) * (256 - int'(y))) / 256);
    endfunction

    // Output-side pop/compare and input-side push, both away from the rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (valid_o && ready_i) begin
                if (sb_q.size() == 0) begin
                    chk("spurious_out", sb_q.size(), 1);
                end else begin
                    e = sb_q.pop_front();
                    n_pop++;
                    chk("y", y_o, e.y);
`ifdef SIGMOID_ACT_DERIV_OUT_EN
                    chk("deriv", deriv_o, e.d);
`endif
                    if (e.lat) chk("latency", cyc - e.cyc, 2);
                    if (in_stream) begin
                        if (strm_n == 0) strm_first = cyc;
                        strm_last = cyc;
                        strm_n++;
                    end
                end
            end
            if (valid_i && ready_o) sb_q.push_back('{exp_y_drv, exp_d_drv, cyc, lat_drv});
            if (!ready_o) saw_stall = 1;
            if (prev_stall) begin
                chk("hold_valid", valid_o, 1);
                chk("hold_y", y_o, prev_y);
            end
            prev_stall = valid_o && !ready_i;
            prev_y     = y_o;
        end else begin
            prev_stall = 0;
        end
    end

    task automatic send(input logic [15:0] z, input logic [15:0] ey, input logic [15:0] ed);
        bit acc;
        acc       = 0;
        valid_i   = 1'b1;
        z_i       = z;
        exp_y_drv = ey;
        exp_d_drv = ed;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            acc = ready_o;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        if (!acc) chk("send_timeout", acc, 1);
    endtask

    task automatic idle(input int n);
        valid_i = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [15:0] dz[13] = '{16'h0000, 16'h0100, 16'hFF00, 16'h0200, 16'h0400, 16'h0800, 16'h7FFF,
                            16'hF800, 16'h8000, 16'h00FF, 16'h0260, 16'h04FF, 16'hFDA0};
    logic [15:0] dy[13] = '{16'h0080, 16'h00C0, 16'h0040, 16'h00E0, 16'h00F8, 16'h0100, 16'h0100,
                            16'h0000, 16'h0000, 16'h00BF, 16'h00EB, 16'h00FF, 16'h0015};
    logic [15:0] dd[13] = '{16'h0040, 16'h0030, 16'h0030, 16'h001C, 16'h0007, 16'h0000, 16'h0000,
                            16'h0000, 16'h0000, 16'h0030, 16'h0013, 16'h0000, 16'h0013};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] z, yv;
        int pop0;
        rst_n   = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        z_i     = '0;
        #2;
        chk("rst_valid_o", valid_o, 0);
        chk("rst_y_o", y_o, 0);
`ifdef SIGMOID_ACT_DERIV_OUT_EN
        chk("rst_deriv_o", deriv_o, 0);
`endif
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rdy_after_rst", ready_o, 1);
        @(posedge clk);
        #1;

        // Directed single samples with latency check.
        lat_drv = 1;
        for (int i = 0; i < 13; i++) begin
            send(dz[i], dy[i], dd[i]);
            idle(4);
        end
        lat_drv = 0;

        // Back-to-back stream of 16.
        in_stream = 1;
        for (int i = 0; i < 16; i++) begin
            z  = (i < 4) ? 16'(i * 16'h0155 - 16'h0300) : 16'($urandom_range(0, 65535));
            yv = ref_y(z);
            send(z, yv, ref_d(yv));
        end
        idle(6);
        in_stream = 0;
        chk("stream_count", strm_n, 16);
        chk("stream_span", strm_last - strm_first, 15);
        chk("stream_drained", sb_q.size(), 0);

        // Backpressure: ready_i low for 5 cycles with valid_i held high.
        saw_stall = 0;
        fork
            begin
                ready_i = 1'b0;
                repeat (5) @(posedge clk);
                #1 ready_i = 1'b1;
            end
            begin
                for (int i = 0; i < 8; i++) begin
                    z  = 16'(i * 16'h00C3 - 16'h0280);
                    yv = ref_y(z);
                    send(z, yv, ref_d(yv));
                end
                valid_i = 1'b0;
            end
        join
        idle(8);
        chk("bp_ready_fell", saw_stall, 1);
        chk("bp_drained", sb_q.size(), 0);

        // Asynchronous reset with two samples in flight.
        send(16'h0200, 16'h00E0, 16'h001C);
        send(16'hFF00, 16'h0040, 16'h0030);
        valid_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid_o", valid_o, 0);
        chk("arst_y_o", y_o, 0);
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        pop0 = n_pop;
        send(16'h0100, 16'h00C0, 16'h0030);
        idle(6);
        chk("arst_one_output", n_pop - pop0, 1);

        chk("sb_empty_end", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/sigmoid_act_stream.md
Name: sigmoid_act_stream

Overview:
Forward-path sigmoid activation for the FFN datapath, the counterpart of the backprop derivative unit. It accepts a stream of signed fixed-point pre-activations and returns sigmoid(z) using the PLAN piecewise-linear approximation. It is a 2-stage elastic pipeline with valid/ready handshakes on both sides. It sits between the systolic array accumulator drain and the activation buffer.

Parameters:
DATA_WIDTH, 16, width of z_i and y_o; two's complement on input, unsigned on output
FRAC_BITS, 8, fractional bits of the Qm.f format on both ports; must be >= 5 and <= DATA_WIDTH-4

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
valid_i  in  1  input sample valid
ready_o  out  1  block can accept the sample this cycle
z_i  in  DATA_WIDTH  signed pre-activation
valid_o  out  1  output sample valid
ready_i  in  1  downstream accepts output
y_o  out  DATA_WIDTH  sigmoid(z), unsigned, range 0 .. 1.0 (1<<FRAC_BITS)
deriv_o  out  DATA_WIDTH  y*(1-y); present only with SIGMOID_ACT_DERIV_OUT_EN

Behaviour:
- Reset is asynchronous, active-low. While rst_ni=0: both stage valids=0, all data registers=0. valid_o=0, y_o=0, deriv_o=0. ready_o=1 from the first cycle after release.
- Handshake: a transfer occurs on a cycle where valid_i&ready_o (input side) or valid_o&ready_i (output side). z_i is sampled only on an input transfer.
- While valid_o=1 and ready_i=0, y_o, deriv_o and valid_o hold stable. valid_o never drops without a transfer.
- Stage enables: en2 = ~v2 | ready_i; en1 = ~v1 | en2; ready_o = en1 (combinational from ready_i).
- With no backpressure: latency is 2 cycles (sample in cycle N, valid_o in cycle N+2) and throughput is 1 sample per cycle.
- Stage 1 register:
  - sign bit s.
  - a = |z| computed in DATA_WIDTH+1 bits, so z = most-negative value gives a = 2^(DATA_WIDTH-1) with no overflow.
  - 2-bit segment code, compared on a (constants scaled by 2^FRAC_BITS):
    - seg3: a >= 5.0
    - seg2: 2.375 <= a < 5.0
    - seg1: 1.0 <= a < 2.375
    - seg0: a < 1.0
- Stage 2: p = slope*a + offset, implemented with shifts and adds only.
  - seg0: a>>2 + 0.5
  - seg1: a>>3 + 0.625
  - seg2: a>>5 + 0.84375
  - seg3: 1.0
  - Shifts truncate toward zero.
  - Result: y = s ? (1.0 - p) : p.
  - Clamp y to 0 .. 1.0; it must never wrap.
- Upper bits above FRAC_BITS+1 of y_o are always 0.
- Reset asserted mid-stream discards all in-flight samples. No partial output is ever presented.
- Simultaneous input and output transfers on a full pipeline are legal and must not stall or drop data.

Optional Feature:
- Macro: SIGMOID_ACT_DERIV_OUT_EN.
- Defined: an extra registered output deriv_o = (y*(1-y)) >> FRAC_BITS, truncated, computed from the stage-2 y.
  - Adds 0 latency: the multiply sits in stage 2 off the stage-1 registers, or y is recomputed. Either way deriv_o aligns with y_o and follows the same hold rules.
  - Reset value is 0.
- Undefined: the deriv_o port and its logic are absent; everything else is unchanged.

Test Plan:
- Reset, then single samples with ready_i=1. Each must give valid_o exactly 2 cycles after acceptance:
  - z=0x0000 -> y=0x0080
  - z=0x0100 -> y=0x00C0
  - z=0xFF00 -> y=0x0040
  - z=0x0200 -> y=0x00E0
  - z=0x0400 -> y=0x00F8
- Saturation and extremes:
  - z=0x0800 -> 0x0100
  - z=0x7FFF -> 0x0100
  - z=0xF800 -> 0x0000
  - z=0x8000 -> 0x0000, with no wrap to a large value.
- Back-to-back stream of 16 consecutive z values with ready_i held 1. Required: 16 outputs on 16 consecutive cycles, in order, matching a golden PLAN model bit-exactly.
- Backpressure: drive ready_i=0 for 5 cycles with valid_i continuously high. Required:
  - ready_o falls once both stages are full.
  - y_o stays stable while stalled.
  - No sample is lost or duplicated after ready_i returns to 1.
- Drop rst_ni asynchronously (between clock edges) with 2 samples in flight. Required: valid_o=0 immediately; after release, the first output corresponds to the first post-reset input.
- With SIGMOID_ACT_DERIV_OUT_EN:
  - z=0 -> deriv_o=0x0040
  - z=0x0100 -> deriv_o=0x0030
  - z=0x0800 -> deriv_o=0x0000
  - deriv_o is aligned with y_o in the same cycle.
